// File: rtl/keyboard_scan.sv
// 4x4 matrix keyboard scanner: column drive, per-frame first-key detection,
// press/release debounce and a one-cycle strobe on each confirmed press.
`timescale 1ns/1ps
module keyboard_scan #(
  parameter int unsigned SCAN_DIV   = 100_000,
  parameter int unsigned DEB_FRAMES = 5
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [3:0] key_row,
  output logic [3:0] key_col,
  output logic       IsPressed,
  output logic [3:0] keyboard_data,
  output logic       key_pulse
);

  localparam int unsigned    SlotW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SlotW-1:0] SlotLast = SlotW'(SCAN_DIV - 1);
  localparam logic [3:0]     DebLast  = 4'(DEB_FRAMES);

  typedef enum logic [1:0] {StIdle, StDebPress, StHeld, StDebRel} state_e;

  logic [3:0]       row_s1_q, row_s2_q;
  logic [SlotW-1:0] slot_q, slot_d;
  logic [1:0]       col_q, col_d;
  logic             found_q, found_d;
  logic [3:0]       code_q, code_d;
  state_e           state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       data_q, data_d;
  logic             pressed_q, pressed_d;
  logic             pulse_q, pulse_d;

  logic       sample, frame_end, hit, frame_found, det_found;
  logic [1:0] hit_row;
  logic [3:0] det_code, cnt_inc;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    unique case ({r, c})
      4'b0000: code = 4'h1;
      4'b0001: code = 4'h2;
      4'b0010: code = 4'h3;
      4'b0011: code = 4'hA;
      4'b0100: code = 4'h4;
      4'b0101: code = 4'h5;
      4'b0110: code = 4'h6;
      4'b0111: code = 4'hB;
      4'b1000: code = 4'h7;
      4'b1001: code = 4'h8;
      4'b1010: code = 4'h9;
      4'b1011: code = 4'hC;
      4'b1100: code = 4'hE;
      4'b1101: code = 4'h0;
      4'b1110: code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  always_comb begin
    sample    = (slot_q == SlotLast);
    frame_end = sample && (col_q == 2'd3);
    slot_d    = sample ? '0 : slot_q + 1'b1;
    col_d     = sample ? col_q + 2'd1 : col_q;

    hit = ~&row_s2_q;
    if (!row_s2_q[0])      hit_row = 2'd0;
    else if (!row_s2_q[1]) hit_row = 2'd1;
    else if (!row_s2_q[2]) hit_row = 2'd2;
    else                   hit_row = 2'd3;

    // Column 0 opens a new frame, so any earlier find is stale there.
    frame_found = found_q && (col_q != 2'd0);
    det_found   = frame_found || hit;
    det_code    = frame_found ? code_q : key_code(hit_row, col_q);

    found_d = found_q;
    code_d  = code_q;
    if (sample) begin
      found_d = det_found;
      code_d  = det_code;
    end
  end

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    pressed_d = pressed_q;
    pulse_d   = 1'b0;
    cnt_inc   = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

    if (frame_end) begin
      unique case (state_q)
        StIdle: begin
          if (det_found) begin
            state_d = StDebPress;
            cand_d  = det_code;
            cnt_d   = 4'd1;
          end
        end
        StDebPress: begin
          if (!det_found) begin
            state_d = StIdle;
          end else if (det_code != cand_q) begin
            cand_d = det_code;
            cnt_d  = 4'd1;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc >= DebLast) begin
              state_d   = StHeld;
              data_d    = cand_q;
              pressed_d = 1'b1;
              pulse_d   = 1'b1;
            end
          end
        end
        StHeld: begin
          if (!det_found) begin
            state_d = StDebRel;
            cnt_d   = 4'd1;
          end
        end
        default: begin
          if (det_found) begin
            state_d = StHeld;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc >= DebLast) begin
              state_d   = StIdle;
              pressed_d = 1'b0;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      row_s1_q  <= 4'hF;
      row_s2_q  <= 4'hF;
      slot_q    <= '0;
      col_q     <= 2'd0;
      found_q   <= 1'b0;
      code_q    <= 4'h0;
      state_q   <= StIdle;
      cand_q    <= 4'h0;
      cnt_q     <= 4'd0;
      data_q    <= 4'h0;
      pressed_q <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      row_s1_q  <= key_row;
      row_s2_q  <= row_s1_q;
      slot_q    <= slot_d;
      col_q     <= col_d;
      found_q   <= found_d;
      code_q    <= code_d;
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      pressed_q <= pressed_d;
      pulse_q   <= pulse_d;
    end
  end

  assign key_col       = ~(4'b0001 << col_q);
  assign IsPressed     = pressed_q;
  assign keyboard_data = data_q;
  assign key_pulse     = pulse_q;

endmodule

// File: tb/tb_keyboard_scan.sv
// Bench for keyboard_scan with SCAN_DIV=4, DEB_FRAMES=3: directed frame table,
// reset corner case and random key frames checked against a frame-level model.
`timescale 1ns/1ps
module tb_keyboard_scan;

  localparam int Deb = 3;
  localparam int FrameCycles = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key_row;
  logic [3:0] key_col;
  logic       is_pressed;
  logic [3:0] kb_data;
  logic       key_pulse;
  logic [15:0] keys;   // bit r*4+c = contact (row r, col c) closed

  int pass_cnt  = 0;
  int total_cnt = 0;
  int pulse_cnt = 0;

  keyboard_scan #(.SCAN_DIV(4), .DEB_FRAMES(Deb)) dut (
    .sys_clk       (clk),
    .sys_rst_n     (rst_n),
    .key_row       (key_row),
    .key_col       (key_col),
    .IsPressed     (is_pressed),
    .keyboard_data (kb_data),
    .key_pulse     (key_pulse)
  );

  always #5 clk = ~clk;

  // Passive matrix: a row reads 0 when a closed contact sits on a driven column.
  always_comb begin
    key_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !key_col[c]) key_row[r] = 1'b0;
  end

  always @(negedge clk) if (key_pulse) pulse_cnt++;

  logic [3:0] code_tab [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC,
                                4'hE, 4'h0, 4'hF, 4'hD};

  // Reference model: runs of identical detected frames decide press and release.
  bit         m_held;
  int         m_run;
  logic [3:0] m_last, m_data;
  bit         m_pulse;
  int         m_pulses = 0;

  task automatic model_reset();
    m_held = 0; m_run = 0; m_last = 4'h0; m_data = 4'h0; m_pulse = 0;
  endtask

  task automatic model_frame(input logic [15:0] ks);
    bit det = 0;
    logic [3:0] dcode = 4'h0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!det && ks[r*4+c]) begin det = 1; dcode = code_tab[r*4+c]; end
    m_pulse = 0;
    if (!m_held) begin
      if (!det) m_run = 0;
      else if (m_run > 0 && dcode == m_last) m_run++;
      else begin m_run = 1; m_last = dcode; end
      if (m_run >= Deb) begin
        m_held = 1; m_data = m_last; m_pulse = 1; m_pulses++; m_run = 0;
      end
    end else begin
      if (det) m_run = 0;
      else m_run++;
      if (m_run >= Deb) begin m_held = 0; m_run = 0; end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    logic [15:0] ks;
    logic        p;
    logic [3:0]  d;
    logic        pu;
  } vec_t;
  vec_t tab[$];

  task automatic add(input logic [15:0] ks, input logic p, input logic [3:0] d, input logic pu);
    vec_t v;
    v.ks = ks; v.p = p; v.d = d; v.pu = pu;
    tab.push_back(v);
  endtask

  // One frame starting right after reset release or a frame end.
  task automatic run_frame(input logic [15:0] ks, input bit use_tab, input vec_t v);
    logic [3:0] exp_col;
    keys = ks;
    for (int j = 1; j <= FrameCycles; j++) begin
      @(posedge clk); #1;
      if (j % 4 == 0) begin
        exp_col = ~(4'b0001 << ((j / 4) % 4));
        chk("key_col", int'(key_col), int'(exp_col));
      end
    end
    model_frame(ks);
    chk("IsPressed", int'(is_pressed), int'(m_held));
    chk("keyboard_data", int'(kb_data), int'(m_data));
    chk("key_pulse", int'(key_pulse), int'(m_pulse));
    if (use_tab) begin
      chk("tab_IsPressed", int'(is_pressed), int'(v.p));
      chk("tab_data", int'(kb_data), int'(v.d));
      chk("tab_pulse", int'(key_pulse), int'(v.pu));
    end
  endtask

  function automatic logic [15:0] k(input int idx);
    logic [15:0] m = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

  initial begin
    vec_t none;
    none = '{ks: 16'h0, p: 1'b0, d: 4'h0, pu: 1'b0};
    keys  = 16'h0;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_key_col", int'(key_col), 4'hE);
    chk("rst_IsPressed", int'(is_pressed), 0);
    chk("rst_data", int'(kb_data), 0);
    chk("rst_pulse", int'(key_pulse), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // '5' held from reset release, then released
    add(k(5), 0, 4'h0, 0); add(k(5), 0, 4'h0, 0); add(k(5), 1, 4'h5, 1); add(k(5), 1, 4'h5, 0);
    add(0, 1, 4'h5, 0); add(0, 1, 4'h5, 0); add(0, 0, 4'h5, 0);
    // '8' two frames, gap, then held
    add(k(9), 0, 4'h5, 0); add(k(9), 0, 4'h5, 0); add(0, 0, 4'h5, 0);
    add(k(9), 0, 4'h5, 0); add(k(9), 0, 4'h5, 0); add(k(9), 1, 4'h8, 1);
    add(0, 1, 4'h8, 0); add(0, 1, 4'h8, 0); add(0, 0, 4'h8, 0);
    // '2' + 'B' together, then only 'B'
    add(k(1) | k(7), 0, 4'h8, 0); add(k(1) | k(7), 0, 4'h8, 0); add(k(1) | k(7), 1, 4'h2, 1);
    add(k(7), 1, 4'h2, 0); add(k(7), 1, 4'h2, 0);
    add(0, 1, 4'h2, 0); add(0, 1, 4'h2, 0); add(0, 0, 4'h2, 0);
    // '4' held, release bounce
    add(k(4), 0, 4'h2, 0); add(k(4), 0, 4'h2, 0); add(k(4), 1, 4'h4, 1);
    add(0, 1, 4'h4, 0); add(0, 1, 4'h4, 0); add(k(4), 1, 4'h4, 0);
    add(0, 1, 4'h4, 0); add(0, 1, 4'h4, 0); add(0, 0, 4'h4, 0);
    // candidate '1' replaced by 'A'
    add(k(0), 0, 4'h4, 0); add(k(0), 0, 4'h4, 0);
    add(k(3), 0, 4'h4, 0); add(k(3), 0, 4'h4, 0); add(k(3), 1, 4'hA, 1);
    add(0, 1, 4'hA, 0); add(0, 1, 4'hA, 0); add(0, 0, 4'hA, 0);

    foreach (tab[i]) run_frame(tab[i].ks, 1, tab[i]);

    // Reset during the third debounce frame of '5'
    run_frame(k(5), 0, none);
    run_frame(k(5), 0, none);
    keys = k(5);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_key_col", int'(key_col), 4'hE);
    chk("midrst_IsPressed", int'(is_pressed), 0);
    chk("midrst_data", int'(kb_data), 0);
    chk("midrst_pulse", int'(key_pulse), 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_frame(k(5), 1, '{ks: k(5), p: 1'b0, d: 4'h0, pu: 1'b0});
    run_frame(k(5), 1, '{ks: k(5), p: 1'b0, d: 4'h0, pu: 1'b0});
    run_frame(k(5), 1, '{ks: k(5), p: 1'b1, d: 4'h5, pu: 1'b1});
    for (int i = 0; i < Deb; i++) run_frame(16'h0, 0, none);

    // Random key sets held for random frame counts, including long holds
    for (int s = 0; s < 50; s++) begin
      logic [15:0] ks;
      int sel;
      int len;
      sel = $urandom_range(0, 3);
      ks  = 16'h0;
      if (sel >= 1) ks = ks | k($urandom_range(0, 15));
      if (sel == 3) ks = ks | k($urandom_range(0, 15));
      len = (s % 10 == 9) ? 20 : $urandom_range(1, 5);
      for (int f = 0; f < len; f++) run_frame(ks, 0, none);
    end
    for (int i = 0; i < Deb; i++) run_frame(16'h0, 0, none);

    @(negedge clk);
    chk("pulse_total", pulse_cnt, m_pulses);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
